// File: rtl/vector_mask_builder.sv
// Packs per-element compare predicates into a MAX_VL-bit mask register and
// hands the finished mask to writeback over a valid/ready handshake.
module vector_mask_builder #(
  parameter int MAX_VL   = 32,
  parameter int VL_WIDTH = $clog2(MAX_VL + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [VL_WIDTH-1:0] vl,
  input  logic                pred_valid,
  input  logic                pred,
  output logic                pred_ready,
  output logic                mask_valid,
  input  logic                mask_ready,
  output logic [MAX_VL-1:0]   mask,
  output logic                busy,
  output logic [VL_WIDTH-1:0] count
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t              state;
  logic [VL_WIDTH-1:0] vl_q;
  logic [VL_WIDTH-1:0] vl_clamp;
  logic [VL_WIDTH-1:0] count_nxt;
  logic [MAX_VL-1:0]   wr_sel;

  assign vl_clamp  = (vl > VL_WIDTH'(MAX_VL)) ? VL_WIDTH'(MAX_VL) : vl;
  assign count_nxt = count + VL_WIDTH'(1);
  // One-hot lane select for the element being written this cycle.
  assign wr_sel    = {{(MAX_VL-1){1'b0}}, 1'b1} << count;

  // Handshake flags are registered alongside the state so they never see
  // pred_valid, mask_ready or start combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vl_q       <= '0;
      mask       <= '0;
      count      <= '0;
      pred_ready <= 1'b0;
      mask_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vl_q  <= vl_clamp;
            mask  <= '0;
            count <= '0;
            busy  <= 1'b1;
            if (vl_clamp == '0) begin
              state      <= DONE;
              mask_valid <= 1'b1;
            end else begin
              state      <= COLLECT;
              pred_ready <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (pred_valid) begin
            mask  <= (mask & ~wr_sel) | (pred ? wr_sel : '0);
            count <= count_nxt;
            if (count_nxt == vl_q) begin
              state      <= DONE;
              pred_ready <= 1'b0;
              mask_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (mask_ready) begin
            state      <= IDLE;
            mask_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pred_ready <= 1'b0;
          mask_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mask_builder.sv
// Scoreboard bench: driver pushes the expected mask/count per instruction,
// a negedge monitor pops and compares on every mask handshake.
module tb_vector_mask_builder;
  localparam int MAXVL = 32;
  localparam int VLW   = 6;

  typedef struct packed {
    logic [MAXVL-1:0] m;
    logic [VLW-1:0]   c;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [VLW-1:0]   vl = '0;
  logic             pred_valid = 1'b0;
  logic             pred = 1'b0;
  logic             pred_ready;
  logic             mask_valid;
  logic             mask_ready = 1'b0;
  logic [MAXVL-1:0] mask;
  logic             busy;
  logic [VLW-1:0]   count;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  int hs_cyc[$];
  int ncyc = 0;
  bit b2b = 0;
  logic [MAXVL-1:0] last_mask = '0;
  int last_cnt = 0;

  vector_mask_builder #(.MAX_VL(MAXVL), .VL_WIDTH(VLW)) dut (
    .clk(clk), .reset(reset), .start(start), .vl(vl),
    .pred_valid(pred_valid), .pred(pred), .pred_ready(pred_ready),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .mask(mask),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: pops on handshake, checks hold-stability while back-pressured.
  initial begin
    bit pend;
    logic [MAXVL-1:0] pm;
    logic [VLW-1:0] pc;
    exp_t e;
    pend = 0;
    pm = '0;
    pc = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset && mask_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mask_valid", 1, 0);
          pend = 0;
        end else begin
          if (pend) begin
            chk("mask_stable", mask, pm);
            chk("count_stable", count, pc);
          end
          if (mask_ready) begin
            e = exp_q.pop_front();
            chk("mask", mask, e.m);
            chk("count", count, e.c);
            hs_cyc.push_back(ncyc);
            pend = 0;
          end else begin
            pend = 1;
            pm = mask;
            pc = count;
          end
        end
      end else begin
        pend = 0;
      end
    end
  end

  // One instruction. smode: 0 no stalls, 1 alternate valid, 2 random stalls.
  task automatic run(input int vl_in, input logic [63:0] preds, input int smode,
                     input int hold, input bit lat, input bit stray);
    int vlq, n, k, rdy;
    bit seen, acc;
    exp_t e;
    vlq = (vl_in > MAXVL) ? MAXVL : vl_in;
    e.m = '0;
    for (int i = 0; i < vlq; i++) e.m[i] = preds[i];
    e.c = VLW'(vlq);
    start = 1'b1;
    vl = VLW'(vl_in);
    @(negedge clk);
    chk("idle_before_start", busy, 0);
    chk("idle_mask_held", mask, last_mask);
    chk("idle_count_held", count, last_cnt);
    @(posedge clk);
    #1;
    start = stray;
    exp_q.push_back(e);
    n = 0; k = 0; rdy = 0; seen = 0;
    while (!seen && n < 400) begin
      case (smode)
        0:       pred_valid = 1'b1;
        1:       pred_valid = (n % 2 == 0);
        default: pred_valid = ($urandom_range(99) >= 40);
      endcase
      pred = (k < 64) ? preds[k] : 1'b0;
      if (stray) vl = VLW'($urandom_range(63));
      @(negedge clk);
      n++;
      if (mask_valid) seen = 1;
      else begin
        if (pred_ready) rdy++;
        acc = pred_ready && pred_valid;
        @(posedge clk);
        #1;
        if (acc) k++;
      end
    end
    if (!seen) chk("mask_valid_timeout", 0, 1);
    chk("preds_accepted", k, vlq);
    if (lat) begin
      chk("mask_valid_latency", n, vlq + 1);
      chk("pred_ready_cycles", rdy, vlq);
    end
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    if (!b2b) begin
      repeat (hold) @(posedge clk);
      #1;
      mask_ready = 1'b1;
      @(posedge clk);
      #1;
      mask_ready = 1'b0;
    end
    start = 1'b0;
    last_mask = e.m;
    last_cnt = vlq;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pred_ready", pred_ready, 0);
    chk("rst_mask_valid", mask_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mask", mask, 0);
    chk("rst_count", count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(4, 64'hD, 0, 0, 1, 0);
    run(3, 64'h7, 1, 2, 0, 0);
    run(0, 64'hFFFF, 0, 1, 1, 0);
    run(32, {64{1'b1}}, 0, 0, 1, 0);
    run(40, {$urandom, $urandom}, 0, 0, 1, 0);
    run(4, 64'hF, 0, 2, 1, 1);
    run(2, 64'h0, 0, 0, 1, 0);

    // Reset after two of five predicates: partial mask dropped silently.
    start = 1'b1; vl = 5;
    @(posedge clk); #1;
    start = 1'b0; pred_valid = 1'b1; pred = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_pred_ready", pred_ready, 0);
    chk("midrst_mask_valid", mask_valid, 0);
    chk("midrst_mask", mask, 0);
    chk("midrst_count", count, 0);
    repeat (4) @(posedge clk);
    #1;
    pred_valid = 1'b0;
    reset = 1'b1; start = 1'b1; vl = 3;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_with_start_busy", busy, 0);
    last_mask = '0;
    last_cnt = 0;
    @(posedge clk); #1;

    b2b = 1; mask_ready = 1'b1;
    s = hs_cyc.size();
    run(2, 64'h2, 0, 0, 1, 0);
    run(2, 64'h1, 0, 0, 1, 0);
    if (hs_cyc.size() >= s + 2) chk("b2b_spacing", hs_cyc[s+1] - hs_cyc[s], 4);
    else chk("b2b_emitted", hs_cyc.size() - s, 2);
    b2b = 0; mask_ready = 1'b0;

    for (int r = 0; r < 20; r++)
      run($urandom_range(40), {$urandom, $urandom}, $urandom_range(2),
          $urandom_range(3), 0, $urandom_range(1));

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
